// File: rtl/hyperram_trafficgen.sv
// hyperram_trafficgen
//   Avalon-MM traffic generator for the HyperRAM simulation bench. It writes
//   an address-derived pattern over the whole word address range in
//   fixed-length bursts, reads every word back, and compares each beat.
//   It reports completion, a sticky error flag and the first mismatch.
//
//   Pattern: data(A) = A resized to G_DATA_SIZE bits, XOR G_PATTERN.
//
//   Optional build macro: TRAFFICGEN_STOP_ON_ERROR_EN
//     defined   : once a mismatch is seen, the current read burst is drained
//                 and the run ends in DONE instead of issuing the next read.
//     undefined : the full address range is always swept.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i                   start a run (honoured in IDLE or DONE only)
//   busy_o / done_o / error_o run status (done and error are sticky)
//   err_address_o / err_expected_o / err_read_o   first mismatch details
//   m_avm_*                   Avalon-MM master towards the controller
//
// States
//   IDLE      | waiting for start_i after reset
//   WRITE     | write bursts back-to-back over the full range
//   READ      | read command held until the slave accepts it
//   READ_WAIT | collecting and checking the read beats of one burst
//   DONE      | run finished, results held until next start_i

module hyperram_trafficgen #(
  parameter int                     G_ADDRESS_SIZE = 4,
  parameter int                     G_DATA_SIZE    = 16,
  parameter int                     G_BURST_LEN    = 4,
  parameter logic [G_DATA_SIZE-1:0] G_PATTERN      = 16'hA5A5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [G_ADDRESS_SIZE-1:0]   err_address_o,
  output logic [G_DATA_SIZE-1:0]      err_expected_o,
  output logic [G_DATA_SIZE-1:0]      err_read_o,
  output logic                        m_avm_write_o,
  output logic                        m_avm_read_o,
  output logic [G_ADDRESS_SIZE-1:0]   m_avm_address_o,
  output logic [G_DATA_SIZE-1:0]      m_avm_writedata_o,
  output logic [G_DATA_SIZE/8-1:0]    m_avm_byteenable_o,
  output logic [7:0]                  m_avm_burstcount_o,
  input  logic [G_DATA_SIZE-1:0]      m_avm_readdata_i,
  input  logic                        m_avm_readdatavalid_i,
  input  logic                        m_avm_waitrequest_i
);

  localparam int BW = (G_BURST_LEN > 1) ? $clog2(G_BURST_LEN) : 1;
  localparam logic [BW-1:0]             LAST_BEAT  = BW'(G_BURST_LEN - 1);
  // Wraps to zero when one burst spans the whole range, which still ends the sweep.
  localparam logic [G_ADDRESS_SIZE-1:0] BURST_STEP = G_ADDRESS_SIZE'(G_BURST_LEN);

`ifdef TRAFFICGEN_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_READ_WAIT, S_DONE
  } state_t;

  state_t                      state_q;
  logic [G_ADDRESS_SIZE-1:0]   base_q;
  logic [BW-1:0]               beat_q;
  logic                        busy_q, done_q, error_q;
  logic [G_ADDRESS_SIZE-1:0]   err_address_q;
  logic [G_DATA_SIZE-1:0]      err_expected_q, err_read_q;
  logic                        write_q, read_q;
  logic [G_ADDRESS_SIZE-1:0]   address_q;
  logic [G_DATA_SIZE-1:0]      writedata_q;

  function automatic logic [G_DATA_SIZE-1:0] pattern(input logic [G_ADDRESS_SIZE-1:0] a);
    return G_DATA_SIZE'(a) ^ G_PATTERN;
  endfunction

  logic [G_ADDRESS_SIZE-1:0] addr_cur;
  logic [G_ADDRESS_SIZE-1:0] base_next;
  logic [G_DATA_SIZE-1:0]    exp_data;
  logic                      mismatch;

  assign addr_cur  = base_q + G_ADDRESS_SIZE'(beat_q);
  assign base_next = base_q + BURST_STEP;
  assign exp_data  = pattern(addr_cur);
  assign mismatch  = (m_avm_readdata_i != exp_data);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      beat_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_address_q  <= '0;
      err_expected_q <= '0;
      err_read_q     <= '0;
      write_q        <= 1'b0;
      read_q         <= 1'b0;
      address_q      <= '0;
      writedata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q        <= S_WRITE;
            base_q         <= '0;
            beat_q         <= '0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_address_q  <= '0;
            err_expected_q <= '0;
            err_read_q     <= '0;
            write_q        <= 1'b1;
            address_q      <= '0;
            writedata_q    <= pattern('0);
          end
        end

        S_WRITE: begin
          if (!m_avm_waitrequest_i) begin
            if (beat_q == LAST_BEAT) begin
              beat_q      <= '0;
              base_q      <= base_next;
              address_q   <= base_next;
              writedata_q <= pattern(base_next);
              if (base_next == '0) begin
                state_q <= S_READ;
                write_q <= 1'b0;
                read_q  <= 1'b1;
              end
            end else begin
              beat_q      <= beat_q + 1'b1;
              writedata_q <= pattern(addr_cur + 1'b1);
            end
          end
        end

        S_READ: begin
          if (!m_avm_waitrequest_i) begin
            read_q  <= 1'b0;
            beat_q  <= '0;
            state_q <= S_READ_WAIT;
          end
        end

        S_READ_WAIT: begin
          if (m_avm_readdatavalid_i) begin
            if (mismatch) begin
              error_q <= 1'b1;
              if (!error_q) begin
                err_address_q  <= addr_cur;
                err_expected_q <= exp_data;
                err_read_q     <= m_avm_readdata_i;
              end
            end
            if (beat_q == LAST_BEAT) begin
              beat_q    <= '0;
              base_q    <= base_next;
              address_q <= base_next;
              if (base_next == '0 || (STOP_ON_ERR && (error_q || mismatch))) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_READ;
                read_q  <= 1'b1;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign error_o            = error_q;
  assign err_address_o      = err_address_q;
  assign err_expected_o     = err_expected_q;
  assign err_read_o         = err_read_q;
  assign m_avm_write_o      = write_q;
  assign m_avm_read_o       = read_q;
  assign m_avm_address_o    = address_q;
  assign m_avm_writedata_o  = writedata_q;
  assign m_avm_byteenable_o = '1;
  assign m_avm_burstcount_o = 8'(G_BURST_LEN);

endmodule

// File: tb/tb_hyperram_trafficgen.sv
module tb_hyperram_trafficgen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        busy_o, done_o, error_o;
  logic [3:0]  err_address_o;
  logic [15:0] err_expected_o, err_read_o;
  logic        m_avm_write_o, m_avm_read_o;
  logic [3:0]  m_avm_address_o;
  logic [15:0] m_avm_writedata_o;
  logic [1:0]  m_avm_byteenable_o;
  logic [7:0]  m_avm_burstcount_o;
  logic [15:0] m_avm_readdata_i;
  logic        m_avm_readdatavalid_i;
  logic        m_avm_waitrequest_i;

  always #5 clk_i = ~clk_i;

  hyperram_trafficgen dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .start_i               (start_i),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .error_o               (error_o),
    .err_address_o         (err_address_o),
    .err_expected_o        (err_expected_o),
    .err_read_o            (err_read_o),
    .m_avm_write_o         (m_avm_write_o),
    .m_avm_read_o          (m_avm_read_o),
    .m_avm_address_o       (m_avm_address_o),
    .m_avm_writedata_o     (m_avm_writedata_o),
    .m_avm_byteenable_o    (m_avm_byteenable_o),
    .m_avm_burstcount_o    (m_avm_burstcount_o),
    .m_avm_readdata_i      (m_avm_readdata_i),
    .m_avm_readdatavalid_i (m_avm_readdatavalid_i),
    .m_avm_waitrequest_i   (m_avm_waitrequest_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Slave controls, written only by the stimulus block.
  bit          stall_en = 1'b0;
  bit          clr_req  = 1'b0;
  bit          corrupt_en [16];
  logic [15:0] corrupt_val [16];

  // Slave state and logs, written only by the slave block.
  logic [15:0] mem [16];
  int          wr_beats   = 0;
  int          wr_cnt     = 0;
  int          wr_base    = 0;
  int          stall_viol = 0;
  int          rd_delay   = 0;
  int          rd_q [$];
  int          rd_addrs [$];
  bit          prev_wr_stall = 1'b0;
  bit          prev_rd_stall = 1'b0;
  logic [3:0]  prev_addr = '0;
  logic [15:0] prev_wdata = '0;

  function automatic logic [15:0] pat(input int a);
    return 16'(a % 16) ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: decides and records everything at the negedge, the DUT
  // samples the resulting inputs at the following posedge.
  always @(negedge clk_i) begin
    int a;
    if (clr_req) for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
    m_avm_waitrequest_i = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (rd_q.size() > 0 && rd_delay == 0) begin
      a = rd_q.pop_front();
      m_avm_readdatavalid_i = 1'b1;
      m_avm_readdata_i = corrupt_en[a] ? corrupt_val[a] : mem[a];
    end else begin
      m_avm_readdatavalid_i = 1'b0;
      m_avm_readdata_i = $urandom_range(0, 65535);
      if (rd_delay > 0) rd_delay--;
    end
    if (prev_wr_stall && (!m_avm_write_o || m_avm_address_o != prev_addr ||
                          m_avm_writedata_o != prev_wdata)) stall_viol++;
    if (prev_rd_stall && (!m_avm_read_o || m_avm_address_o != prev_addr)) stall_viol++;
    if (!rst_i && m_avm_write_o && !m_avm_waitrequest_i) begin
      if (wr_cnt == 0) wr_base = int'(m_avm_address_o);
      else if (int'(m_avm_address_o) != wr_base) stall_viol++;
      mem[(wr_base + wr_cnt) % 16] = m_avm_writedata_o;
      wr_beats++;
      wr_cnt = (wr_cnt + 1) % 4;
    end
    if (!rst_i && m_avm_read_o && !m_avm_waitrequest_i) begin
      rd_addrs.push_back(int'(m_avm_address_o));
      for (int k = 0; k < 4; k++) rd_q.push_back((int'(m_avm_address_o) + k) % 16);
      rd_delay = 2;
    end
    prev_wr_stall = !rst_i && m_avm_write_o && m_avm_waitrequest_i;
    prev_rd_stall = !rst_i && m_avm_read_o && m_avm_waitrequest_i;
    prev_addr  = m_avm_address_o;
    prev_wdata = m_avm_writedata_o;
  end

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_busy"},  busy_o, 0);
    chk({nm, "_done"},  done_o, 0);
    chk({nm, "_error"}, error_o, 0);
    chk({nm, "_erraddr"}, err_address_o, 0);
    chk({nm, "_errexp"},  err_expected_o, 0);
    chk({nm, "_errread"}, err_read_o, 0);
    chk({nm, "_write"}, m_avm_write_o, 0);
    chk({nm, "_read"},  m_avm_read_o, 0);
    chk({nm, "_addr"},  m_avm_address_o, 0);
    chk({nm, "_wdata"}, m_avm_writedata_o, 0);
    chk({nm, "_be"},    m_avm_byteenable_o, 2'b11);
    chk({nm, "_bcnt"},  m_avm_burstcount_o, 4);
  endtask

  task automatic pulse_start();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  // One full run, checked against expectations derived from the corruption
  // table: the first corrupted word in ascending read order is the reported
  // error, and the read bursts are the bases 0,4,8,12 (cut short after the
  // failing burst when stop-on-error is built in).
  task automatic do_run(input string nm, input bit poke_start);
    int wb0, rb0, sv0, cyc, first, n_reads;
    @(posedge clk_i); clr_req = 1'b1;
    @(posedge clk_i); clr_req = 1'b0;
    wb0 = wr_beats; rb0 = rd_addrs.size(); sv0 = stall_viol;
    pulse_start();
    chk({nm, "_busy_lat"},  busy_o, 1);
    chk({nm, "_write_lat"}, m_avm_write_o, 1);
    chk({nm, "_done_clr"},  done_o, 0);
    chk({nm, "_err_clr"},   error_o, 0);
    if (poke_start) begin
      repeat (3) @(negedge clk_i);
      start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
    end
    cyc = 0;
    while (!done_o && cyc < 3000) begin @(negedge clk_i); cyc++; end
    chk({nm, "_done"}, done_o, 1);
    chk({nm, "_busy_end"}, busy_o, 0);

    first = -1;
    for (int a = 0; a < 16; a++)
      if (first < 0 && corrupt_en[a] && corrupt_val[a] != pat(a)) first = a;
    n_reads = 4;
`ifdef TRAFFICGEN_STOP_ON_ERROR_EN
    if (first >= 0) n_reads = first / 4 + 1;
`endif
    chk({nm, "_error"}, error_o, (first >= 0) ? 1 : 0);
    if (first >= 0) begin
      chk({nm, "_erraddr"}, err_address_o, first);
      chk({nm, "_errexp"},  err_expected_o, pat(first));
      chk({nm, "_errread"}, err_read_o, corrupt_val[first]);
    end
    chk({nm, "_wr_beats"}, wr_beats - wb0, 16);
    chk({nm, "_rd_count"}, rd_addrs.size() - rb0, n_reads);
    for (int i = 0; i < n_reads; i++)
      if (rb0 + i < rd_addrs.size()) chk({nm, "_rd_addr"}, rd_addrs[rb0 + i], 4 * i);
    for (int a = 0; a < 16; a++) chk({nm, "_mem"}, mem[a], pat(a));
    chk({nm, "_stall_stable"}, stall_viol - sv0, 0);
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    int cyc, rb0, n;
    for (int i = 0; i < 16; i++) begin corrupt_en[i] = 1'b0; corrupt_val[i] = '0; end
    rst_i = 1'b1; start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check_idle_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("idle_stays", busy_o, 0);

    // Ideal slave, clean run.
    do_run("ideal", 1'b0);
    chk("word5_value", mem[5], 16'hA5A0);

    // Corrupt address 6 and 9.
    corrupt_en[6] = 1'b1; corrupt_val[6] = 16'h0000;
    corrupt_en[9] = 1'b1; corrupt_val[9] = pat(9) ^ 16'($urandom_range(1, 65535));
    do_run("err69", 1'b0);
    chk("err69_fixed_addr", err_address_o, 6);
    chk("err69_fixed_exp",  err_expected_o, 16'hA5A3);

    // Restart from DONE after an error, with a stray start during WRITE.
    corrupt_en[6] = 1'b0; corrupt_en[9] = 1'b0;
    do_run("restart", 1'b1);

    // Random slave stalls on writes and read commands.
    stall_en = 1'b1;
    do_run("stall", 1'b0);

    // Random corruption pattern with stalls.
    for (int i = 0; i < 16; i++) begin
      corrupt_en[i]  = ($urandom_range(0, 5) == 0);
      corrupt_val[i] = pat(i) ^ 16'($urandom_range(1, 65535));
    end
    do_run("rand", 1'b0);
    for (int i = 0; i < 16; i++) corrupt_en[i] = 1'b0;
    stall_en = 1'b0;

    // Reset during the second read burst; its late beats must be ignored.
    corrupt_en[5] = 1'b1; corrupt_val[5] = 16'h0000;
    rb0 = rd_addrs.size();
    pulse_start();
    cyc = 0;
    while (rd_addrs.size() < rb0 + 2 && cyc < 500) begin @(negedge clk_i); cyc++; end
    n = rd_addrs.size() - rb0;
    chk("midrst_reached_read2", n, 2);
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    check_idle_outputs("midrst");
    repeat (10) @(negedge clk_i);
    chk("midrst_late_error", error_o, 0);
    chk("midrst_late_busy",  busy_o, 0);
    chk("midrst_late_read",  m_avm_read_o, 0);
    chk("midrst_late_done",  done_o, 0);
    corrupt_en[5] = 1'b0;
    do_run("fresh", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
